muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit that sits between register-file read and register-file write-back. It consumes the rs1/rs2 read data and rd address for an M-extension instruction. It computes the result over multiple cycles and delivers result, rd address and a one-cycle write-enable pulse that drive the register file's write_data/write_addr/write_enable. Busy stalls the core's issue logic.

---
 rtl/muldiv_unit_if.sv | 25 ++
 rtl/muldiv_unit.sv | 140 ++++++++++++++
 tb/tb_muldiv_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Handshake/result bundle between issue/regfile logic and the RV32M multiply/divide unit.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic [4:0]      dest_addr;
  logic            busy;
  logic            result_valid;
  logic [XLEN-1:0] result;
  logic [4:0]      result_addr;
  logic            result_we;

  modport master (
    output start, op, operand_a, operand_b, dest_addr,
    input  busy, result_valid, result, result_addr, result_we
  );

  modport slave (
    input  start, op, operand_a, operand_b, dest_addr,
    output busy, result_valid, result, result_addr, result_we
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring divide on magnitudes,
// XLEN CALC cycles per op, divide-by-zero and signed overflow finish through a one-cycle path.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [2:0]      op_q;
  logic [4:0]      addr_q;
  logic            neg_q;
  logic            neg_r;
  logic [XLEN-1:0] mag;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] res_q;
  logic [4:0]      res_addr_q;

  // Operand decode for the request being offered in IDLE
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] special_res;

  always_comb begin
    a_signed    = bus.op[2] ? !bus.op[0] : (bus.op != 3'b011);
    b_signed    = bus.op[2] ? !bus.op[0] : !bus.op[1];
    a_neg       = a_signed & bus.operand_a[XLEN-1];
    b_neg       = b_signed & bus.operand_b[XLEN-1];
    abs_a       = a_neg ? (~bus.operand_a + 1'b1) : bus.operand_a;
    abs_b       = b_neg ? (~bus.operand_b + 1'b1) : bus.operand_b;
    div_zero    = bus.op[2] & (bus.operand_b == '0);
    div_ovf     = bus.op[2] & !bus.op[0]
                & (bus.operand_a == {1'b1, {(XLEN-1){1'b0}}})
                & (bus.operand_b == {XLEN{1'b1}});
    special_res = '0;
    if (div_zero)
      special_res = bus.op[1] ? bus.operand_a : {XLEN{1'b1}};
    else
      special_res = bus.op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // One iteration: multiply keeps {hi,lo} as partial product / shifting multiplier,
  // divide keeps hi as partial remainder and lo as dividend shifting into quotient.
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_sh;
  logic [XLEN:0]     div_diff;
  logic              div_ok;
  logic [XLEN-1:0]   nxt_hi, nxt_lo;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, final_res;

  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, mag} : '0);
    div_sh   = {hi, lo[XLEN-1]};
    div_diff = div_sh - {1'b0, mag};
    div_ok   = !div_diff[XLEN];
    if (op_q[2]) begin
      nxt_hi = div_ok ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
      nxt_lo = {lo[XLEN-2:0], div_ok};
    end else begin
      nxt_hi = mul_sum[XLEN:1];
      nxt_lo = {mul_sum[0], lo[XLEN-1:1]};
    end
    prod_s = neg_q ? (~{nxt_hi, nxt_lo} + 1'b1) : {nxt_hi, nxt_lo};
    quo_s  = neg_q ? (~nxt_lo + 1'b1) : nxt_lo;
    rem_s  = neg_r ? (~nxt_hi + 1'b1) : nxt_hi;
    case (op_q)
      3'b000:                 final_res = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_res = quo_s;
      default:                final_res = rem_s;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      op_q       <= '0;
      addr_q     <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      mag        <= '0;
      hi         <= '0;
      lo         <= '0;
      res_q      <= '0;
      res_addr_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            op_q   <= bus.op;
            addr_q <= bus.dest_addr;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            if (div_zero || div_ovf) begin
              res_q      <= special_res;
              res_addr_q <= bus.dest_addr;
              state      <= S_DONE;
            end else begin
              hi    <= '0;
              lo    <= bus.op[2] ? abs_a : abs_b;
              mag   <= bus.op[2] ? abs_b : abs_a;
              cnt   <= CW'(XLEN);
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          hi  <= nxt_hi;
          lo  <= nxt_lo;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            res_q      <= final_res;
            res_addr_q <= addr_q;
            state      <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy         = (state != S_IDLE);
  assign bus.result_valid = (state == S_DONE);
  assign bus.result       = res_q;
  assign bus.result_addr  = res_addr_q;
  assign bus.result_we    = (state == S_DONE) && (res_addr_q != 5'd0);
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  muldiv_unit_if #(.XLEN(32)) bus ();
  muldiv_unit #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    bit ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'h0, a});
    ub  = longint'({32'h0, b});
    ia  = a;
    ib  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(ia / ib));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : (ovf ? 32'h0 : 32'(ia % ib));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    logic [31:0] exp;
    int lat, busy_cnt;
    bit special, got;
    exp     = ref_model(op, a, b);
    special = op[2] && ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.operand_a = a; bus.operand_b = b; bus.dest_addr = rd;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.operand_a = $urandom; bus.operand_b = $urandom;
    bus.op = 3'($urandom); bus.dest_addr = 5'($urandom);
    lat = 0; busy_cnt = 0; got = 0;
    while (!got && lat < 100) begin
      @(negedge clk);
      lat++;
      if (bus.busy) busy_cnt++;
      if (bus.result_valid) got = 1;
    end
    chk("latency", 32'(lat), special ? 32'd1 : 32'd33);
    chk("busy_cycles", 32'(busy_cnt), special ? 32'd1 : 32'd33);
    chk("result", bus.result, exp);
    chk("result_addr", 32'(bus.result_addr), 32'(rd));
    chk("result_we", 32'(bus.result_we), 32'(rd != 0));
    @(negedge clk);
    chk("valid_drop", 32'(bus.result_valid), 32'd0);
    chk("busy_drop", 32'(bus.busy), 32'd0);
    chk("result_hold", bus.result, exp);
  endtask

  initial begin
    int comps;
    logic [31:0] last;
    vectors = 0; miscompares = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = '0; bus.operand_a = '0; bus.operand_b = '0; bus.dest_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_valid", 32'(bus.result_valid), 32'd0);
    chk("rst_we", 32'(bus.result_we), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_addr", 32'(bus.result_addr), 32'd0);
    rst_n = 1'b1;

    // Directed operations
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6);
    run_op(3'd5, 32'hFFFF_FFF9, 32'd2, 5'd7);
    run_op(3'd7, 32'hFFFF_FFF9, 32'd2, 5'd8);
    run_op(3'd4, 32'd5, 32'd0, 5'd9);
    run_op(3'd7, 32'd5, 32'd0, 5'd10);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);

    // start while busy is ignored
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd0; bus.operand_a = 32'd3; bus.operand_b = 32'd4; bus.dest_addr = 5'd13;
    @(negedge clk);
    bus.op = 3'd5; bus.operand_a = 32'd100; bus.operand_b = 32'd7; bus.dest_addr = 5'd14;
    comps = 0; last = '0;
    for (int i = 0; i < 60; i++) begin
      if (i == 10) bus.start = 1'b0;
      @(negedge clk);
      if (bus.result_valid) begin comps++; last = bus.result; end
    end
    chk("ignored_count", 32'(comps), 32'd1);
    chk("ignored_result", last, 32'd12);
    chk("ignored_idle", 32'(bus.busy), 32'd0);
    run_op(3'd0, 32'd2, 32'd2, 5'd0);

    // Reset in the middle of CALC
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd0; bus.operand_a = 32'd1234; bus.operand_b = 32'd5678; bus.dest_addr = 5'd9;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_valid", 32'(bus.result_valid), 32'd0);
    chk("midrst_we", 32'(bus.result_we), 32'd0);
    chk("midrst_result", bus.result, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    comps = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.result_valid || bus.busy) comps++;
    end
    chk("post_rst_quiet", 32'(comps), 32'd0);
    run_op(3'd1, 32'hDEAD_BEEF, 32'h1234_5678, 5'd21);

    // Randomized operations with biased corner operands
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      int sel;
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel == 2) rb = 32'($urandom_range(1, 15));
      run_op(rop, ra, rb, 5'($urandom_range(0, 31)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
